// File: rtl/euler_step_engine.sv
// Explicit Euler step responder: X1 = X0 + H*DX over data-RAM port B, with commit of X1 into X0 on accept.
// Optional EULER_SAT_EN: saturate the X1 sum on signed overflow instead of wrapping.
module euler_step_engine #(
   parameter int WORD_SIZE    = 64,
   parameter int ADDRESS_SIZE = 10,
   parameter int FRAC_BITS    = 32,
   parameter int MAX_N        = 50,
   parameter int N_ADDRESS    = 0,
   parameter int H_ADDRESS    = 17,
   parameter int DX_ADDRESS   = 69,
   parameter int X0_ADDRESS   = 119,
   parameter int X1_ADDRESS   = 169
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    h_done,
   input  logic                    error_ok,
   output logic                    start_cal_err,
   output logic                    busy,
   output logic [31:0]             step_count,
   output logic [ADDRESS_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]    mem_wdata,
   output logic                    mem_we,
   input  logic [WORD_SIZE-1:0]    mem_rdata,
   output logic [2:0]              fsm_state
);
   localparam int IDXW = $clog2(MAX_N + 1);

   typedef enum logic [2:0] {IDLE, LOAD_N, WAIT_HDONE, COMMIT, LOAD_H, CALC, SIGNAL} state_t;

   state_t                       state, state_nx;
   logic [1:0]                   phase, phase_nx;
   logic [IDXW-1:0]              idx, idx_nx, n_reg, n_clamp;
   logic                         first, err_cap, commit_go, last;
   logic signed [WORD_SIZE-1:0]  h_reg, x0_reg, step_p, sum_wrap, sum_x1;
   logic signed [2*WORD_SIZE-1:0] h_ext, d_ext, prod;

   assign h_ext    = {{WORD_SIZE{h_reg[WORD_SIZE-1]}}, h_reg};
   assign d_ext    = {{WORD_SIZE{mem_rdata[WORD_SIZE-1]}}, mem_rdata};
   assign prod     = h_ext * d_ext;
   assign step_p   = WORD_SIZE'(prod >>> FRAC_BITS);
   assign sum_wrap = x0_reg + step_p;

`ifdef EULER_SAT_EN
   logic ovf;
   assign ovf    = (x0_reg[WORD_SIZE-1] == step_p[WORD_SIZE-1]) &&
                   (sum_wrap[WORD_SIZE-1] != x0_reg[WORD_SIZE-1]);
   assign sum_x1 = !ovf ? sum_wrap :
                   x0_reg[WORD_SIZE-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}} : {1'b0, {(WORD_SIZE-1){1'b1}}};
`else
   assign sum_x1 = sum_wrap;
`endif

   assign n_clamp   = (mem_rdata > WORD_SIZE'(MAX_N)) ? IDXW'(MAX_N) : IDXW'(mem_rdata);
   assign commit_go = !first && err_cap;
   assign last      = ((idx + IDXW'(1)) == n_reg);
   assign busy      = (state != IDLE) && (state != WAIT_HDONE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         phase <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         idx   <= idx_nx;
      end
   end

   // Handshake: a request is taken when h_done is seen high in WAIT_HDONE; start_cal_err then
   // stays high until h_done is seen low, which completes the exchange (four-phase, level based).
   always_comb begin
      state_nx  = state;
      phase_nx  = phase;
      idx_nx    = idx;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      case (state)
         IDLE: if (enable) begin
            state_nx = LOAD_N;
            phase_nx = 2'd0;
         end
         LOAD_N: begin
            mem_addr = ADDRESS_SIZE'(N_ADDRESS);
            if (phase == 2'd0) phase_nx = 2'd1;
            else begin
               phase_nx = 2'd0;
               state_nx = WAIT_HDONE;
            end
         end
         WAIT_HDONE: begin
            if (phase == 2'd0) begin
               if (h_done) phase_nx = 2'd1;
            end else begin
               phase_nx = 2'd0;
               idx_nx   = '0;
               state_nx = (commit_go && n_reg != '0) ? COMMIT : LOAD_H;
            end
         end
         COMMIT: begin
            if (phase == 2'd0) begin
               mem_addr = ADDRESS_SIZE'(X1_ADDRESS) + ADDRESS_SIZE'(idx);
               phase_nx = 2'd1;
            end else begin
               mem_addr  = ADDRESS_SIZE'(X0_ADDRESS) + ADDRESS_SIZE'(idx);
               mem_wdata = mem_rdata;
               mem_we    = 1'b1;
               phase_nx  = 2'd0;
               idx_nx    = last ? '0 : idx + IDXW'(1);
               if (last) state_nx = LOAD_H;
            end
         end
         LOAD_H: begin
            mem_addr = ADDRESS_SIZE'(H_ADDRESS);
            if (phase == 2'd0) phase_nx = 2'd1;
            else begin
               phase_nx = 2'd0;
               idx_nx   = '0;
               state_nx = (n_reg == '0) ? SIGNAL : CALC;
            end
         end
         CALC: begin
            if (phase == 2'd0) begin
               mem_addr = ADDRESS_SIZE'(X0_ADDRESS) + ADDRESS_SIZE'(idx);
               phase_nx = 2'd1;
            end else if (phase == 2'd1) begin
               mem_addr = ADDRESS_SIZE'(DX_ADDRESS) + ADDRESS_SIZE'(idx);
               phase_nx = 2'd2;
            end else begin
               mem_addr  = ADDRESS_SIZE'(X1_ADDRESS) + ADDRESS_SIZE'(idx);
               mem_wdata = sum_x1;
               mem_we    = 1'b1;
               phase_nx  = 2'd0;
               idx_nx    = last ? '0 : idx + IDXW'(1);
               if (last) state_nx = SIGNAL;
            end
         end
         SIGNAL: if (!h_done) state_nx = WAIT_HDONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         first         <= 1'b0;
         err_cap       <= 1'b0;
         n_reg         <= '0;
         h_reg         <= '0;
         x0_reg        <= '0;
         step_count    <= '0;
         start_cal_err <= 1'b0;
      end else begin
         start_cal_err <= (state == SIGNAL) && h_done;
         case (state)
            IDLE:   if (enable) first <= 1'b1;
            LOAD_N: if (phase == 2'd1) n_reg <= n_clamp;
            WAIT_HDONE: begin
               if (phase == 2'd0 && h_done) err_cap <= error_ok;
               // With N = 0 the commit has no elements but still counts as a step.
               if (phase == 2'd1 && commit_go && n_reg == '0) step_count <= step_count + 32'd1;
            end
            COMMIT: if (phase == 2'd1 && last) step_count <= step_count + 32'd1;
            LOAD_H: if (phase == 2'd1) begin
               h_reg <= mem_rdata;
               first <= 1'b0;
            end
            CALC:   if (phase == 2'd1) x0_reg <= mem_rdata;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_euler_step_engine.sv
// Bench for euler_step_engine: RAM model, reference Euler model, scenario tasks and one summary line.
`timescale 1ns/1ps
module tb_euler_step_engine;
   localparam int AW = 10;
   localparam int MAX_N = 50;
   localparam int N_A = 0, H_A = 17, DX_A = 69, X0_A = 119, X1_A = 169;
   localparam logic [63:0] ONE = 64'h1_0000_0000;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, h_done = 1'b0, error_ok = 1'b0;
   logic        start_cal_err, busy, mem_we;
   logic [31:0] step_count;
   logic [AW-1:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [2:0]  fsm_state;
   logic [63:0] ram [0:1023];
   int          wr_count = 0;
   int          checks = 0, passed = 0;

   euler_step_engine dut (
      .clk(clk), .reset(reset), .enable(enable), .h_done(h_done), .error_ok(error_ok),
      .start_cal_err(start_cal_err), .busy(busy), .step_count(step_count),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
      mem_rdata <= ram[mem_addr];
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Fixed-point Euler update: x0 + floor(h*dx / 2^32), wrapped or saturated to 64 bits.
   function automatic logic [63:0] model_next(input logic [63:0] x0, input logic [63:0] h, input logic [63:0] dx);
      logic signed [127:0] prod;
      logic signed [64:0]  s;
      prod = $signed({{64{h[63]}}, h}) * $signed({{64{dx[63]}}, dx});
      prod = prod >>> 32;
      s = $signed({x0[63], x0}) + $signed({prod[63], prod[63:0]});
`ifdef EULER_SAT_EN
      if (s > $signed(65'h0_7FFF_FFFF_FFFF_FFFF)) return 64'h7FFF_FFFF_FFFF_FFFF;
      if (s < $signed(65'h1_8000_0000_0000_0000)) return 64'h8000_0000_0000_0000;
`endif
      return s[63:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 1024; i++) ram[i] = 64'hA5A5_5A5A_0000_0000 | 64'(i);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; h_done = 1'b0; error_ok = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic start_engine();
      enable = 1'b1; tick();
      enable = 1'b0; tick(); tick();
   endtask

   task automatic run_step(input logic err, output int lat);
      error_ok = err;
      h_done = 1'b1;
      lat = -1;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (start_cal_err === 1'b1) begin
            lat = k;
            break;
         end
      end
      error_ok = 1'b0;
   endtask

   task automatic release_hd();
      h_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      int busy_seen = 0;
      reset = 1'b1; tick(); tick(); tick();
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (start_cal_err !== 1'b0) $display("FAIL reset_sce: got %b want 0", start_cal_err); else passed++;
      checks++; if (step_count !== 32'd0) $display("FAIL reset_step_count: got %0d want 0", step_count); else passed++;
      checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); else passed++;
      checks++; if (mem_wdata !== 64'd0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
      reset = 1'b0; h_done = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (busy !== 1'b0 || start_cal_err !== 1'b0) busy_seen++;
      end
      h_done = 1'b0;
      checks++; if (busy_seen !== 0) $display("FAIL reset_hdone_ignored: active cycles %0d want 0", busy_seen); else passed++;
   endtask

   task automatic test_first_accept();
      int lat;
      do_reset(); fill_ram();
      ram[N_A] = 64'd1; ram[H_A] = 64'h8000_0000; ram[X0_A] = ONE; ram[DX_A] = 64'h2_0000_0000;
      start_engine();
      run_step(1'b1, lat);
      checks++; if (lat !== 7) $display("FAIL first_latency: got %0d want 7", lat); else passed++;
      checks++; if (ram[X1_A] !== 64'h2_0000_0000) $display("FAIL first_x1: got %h want 200000000", ram[X1_A]); else passed++;
      checks++; if (ram[X0_A] !== ONE) $display("FAIL first_x0: got %h want 100000000", ram[X0_A]); else passed++;
      checks++; if (step_count !== 32'd0) $display("FAIL first_step_count: got %0d want 0", step_count); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL first_busy_signal: got %b want 1", busy); else passed++;
      release_hd();
      checks++; if (start_cal_err !== 1'b0) $display("FAIL first_sce_drop: got %b want 0", start_cal_err); else passed++;
      run_step(1'b1, lat);
      checks++; if (lat !== 9) $display("FAIL accept_latency: got %0d want 9", lat); else passed++;
      checks++; if (ram[X0_A] !== 64'h2_0000_0000) $display("FAIL accept_x0: got %h want 200000000", ram[X0_A]); else passed++;
      checks++; if (step_count !== 32'd1) $display("FAIL accept_step_count: got %0d want 1", step_count); else passed++;
      checks++; if (ram[X1_A] !== 64'h3_0000_0000) $display("FAIL accept_x1: got %h want 300000000", ram[X1_A]); else passed++;
      release_hd();
   endtask

   task automatic test_reject();
      int lat;
      do_reset(); fill_ram();
      ram[N_A] = 64'd1; ram[H_A] = 64'h8000_0000; ram[X0_A] = ONE; ram[DX_A] = 64'h2_0000_0000;
      start_engine();
      run_step(1'b0, lat);
      release_hd();
      ram[H_A] = 64'h4000_0000;
      run_step(1'b0, lat);
      checks++; if (lat !== 7) $display("FAIL reject_latency: got %0d want 7", lat); else passed++;
      checks++; if (ram[X0_A] !== ONE) $display("FAIL reject_x0: got %h want 100000000", ram[X0_A]); else passed++;
      checks++; if (ram[X1_A] !== 64'h1_8000_0000) $display("FAIL reject_x1: got %h want 180000000", ram[X1_A]); else passed++;
      checks++; if (step_count !== 32'd0) $display("FAIL reject_step_count: got %0d want 0", step_count); else passed++;
      release_hd();
   endtask

   task automatic test_negative_clamp();
      int lat;
      logic [63:0] x0v [MAX_N];
      do_reset(); fill_ram();
      ram[N_A] = 64'd60; ram[H_A] = ONE;
      for (int i = 0; i < MAX_N; i++) begin
         x0v[i] = {$urandom_range(0, 32'h7FFF_FFFF), $urandom};
         ram[X0_A + i] = x0v[i];
         ram[DX_A + i] = -ONE;
      end
      start_engine();
      run_step(1'b0, lat);
      checks++; if (lat !== 154) $display("FAIL clamp_latency: got %0d want 154", lat); else passed++;
      for (int i = 0; i < MAX_N; i++) begin
         checks++;
         if (ram[X1_A + i] !== x0v[i] - ONE) $display("FAIL clamp_x1[%0d]: got %h want %h", i, ram[X1_A + i], x0v[i] - ONE);
         else passed++;
      end
      for (int a = 219; a < 1024; a++) begin
         checks++;
         if (ram[a] !== (64'hA5A5_5A5A_0000_0000 | 64'(a))) $display("FAIL clamp_untouched[%0d]: got %h", a, ram[a]);
         else passed++;
      end
      release_hd();
   endtask

   task automatic test_overflow();
      int lat;
      logic [63:0] exp_x1;
`ifdef EULER_SAT_EN
      exp_x1 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
      exp_x1 = 64'h8000_0000_0000_0000;
`endif
      do_reset(); fill_ram();
      ram[N_A] = 64'd1; ram[H_A] = 64'd1; ram[X0_A] = 64'h7FFF_FFFF_FFFF_FFFF; ram[DX_A] = ONE;
      start_engine();
      run_step(1'b0, lat);
      checks++; if (ram[X1_A] !== exp_x1) $display("FAIL overflow_x1: got %h want %h", ram[X1_A], exp_x1); else passed++;
      release_hd();
   endtask

   task automatic test_random(input int n, input int steps);
      logic [63:0] x0_m [MAX_N];
      logic [63:0] x1_m [MAX_N];
      logic [63:0] dx_m [MAX_N];
      logic [63:0] h_m;
      logic        acc;
      int          cnt, lat, exp_lat;
      do_reset(); fill_ram();
      ram[N_A] = 64'(n);
      for (int i = 0; i < n; i++) begin
         x0_m[i] = {$urandom, $urandom};
         dx_m[i] = {$urandom, $urandom};
         ram[X0_A + i] = x0_m[i];
         ram[DX_A + i] = dx_m[i];
      end
      cnt = 0;
      start_engine();
      enable = 1'b1;
      for (int s = 0; s < steps; s++) begin
         h_m = {$urandom, $urandom};
         ram[H_A] = h_m;
         acc = 1'($urandom_range(0, 1));
         exp_lat = 4 + 3 * n;
         if (s > 0 && acc) begin
            for (int i = 0; i < n; i++) x0_m[i] = x1_m[i];
            cnt++;
            exp_lat += 2 * n;
         end
         for (int i = 0; i < n; i++) x1_m[i] = model_next(x0_m[i], h_m, dx_m[i]);
         run_step(acc, lat);
         checks++; if (lat !== exp_lat) $display("FAIL rand_latency n=%0d s=%0d: got %0d want %0d", n, s, lat, exp_lat); else passed++;
         checks++; if (step_count !== 32'(cnt)) $display("FAIL rand_step_count n=%0d s=%0d: got %0d want %0d", n, s, step_count, cnt); else passed++;
         for (int i = 0; i < n; i++) begin
            checks++;
            if (ram[X0_A + i] !== x0_m[i]) $display("FAIL rand_x0[%0d] s=%0d: got %h want %h", i, s, ram[X0_A + i], x0_m[i]);
            else passed++;
            checks++;
            if (ram[X1_A + i] !== x1_m[i]) $display("FAIL rand_x1[%0d] s=%0d: got %h want %h", i, s, ram[X1_A + i], x1_m[i]);
            else passed++;
         end
         release_hd();
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [63:0] x0v [5];
      logic [63:0] dxv [5];
      logic [63:0] h;
      int w0, active;
      do_reset(); fill_ram();
      h = {$urandom, $urandom};
      ram[N_A] = 64'd5; ram[H_A] = h;
      for (int i = 0; i < 5; i++) begin
         x0v[i] = {$urandom, $urandom}; dxv[i] = {$urandom, $urandom};
         ram[X0_A + i] = x0v[i]; ram[DX_A + i] = dxv[i];
      end
      start_engine();
      h_done = 1'b1;
      for (int k = 0; k < 14; k++) tick();
      checks++; if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b want 1", busy); else passed++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
      checks++; if (mem_addr !== '0) $display("FAIL midreset_mem_addr: got %0d want 0", mem_addr); else passed++;
      checks++; if (mem_we !== 1'b0) $display("FAIL midreset_mem_we: got %b want 0", mem_we); else passed++;
      checks++; if (mem_wdata !== 64'd0) $display("FAIL midreset_mem_wdata: got %h want 0", mem_wdata); else passed++;
      checks++; if (start_cal_err !== 1'b0) $display("FAIL midreset_sce: got %b want 0", start_cal_err); else passed++;
      w0 = wr_count;
      active = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (busy !== 1'b0 || start_cal_err !== 1'b0) active++;
      end
      h_done = 1'b0;
      checks++; if (active !== 0) $display("FAIL midreset_ignored: active cycles %0d want 0", active); else passed++;
      checks++; if (wr_count !== w0) $display("FAIL midreset_writes: got %0d want %0d", wr_count - w0, 0); else passed++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ram[X1_A + i] !== model_next(x0v[i], h, dxv[i]))
            $display("FAIL midreset_partial_x1[%0d]: got %h want %h", i, ram[X1_A + i], model_next(x0v[i], h, dxv[i]));
         else passed++;
      end
      checks++;
      if (ram[X1_A + 3] !== (64'hA5A5_5A5A_0000_0000 | 64'(X1_A + 3))) $display("FAIL midreset_x1_3: got %h", ram[X1_A + 3]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_first_accept();
      test_reject();
      test_negative_clamp();
      test_overflow();
      test_random(0, 4);
      test_random(1 + $urandom_range(0, 5), 8);
      test_random(MAX_N, 3);
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
